// File: rtl/axi_long_wr_split.sv
// Splits one long AXI write into boundary-safe INCR bursts.
// Ports: clock/rst_n; axi_in_* slave write side; axi_out_* master write side.
module axi_long_wr_split #(
  parameter int DSIZE       = 64,
  parameter int IDSIZE      = 4,
  parameter int ASIZE       = 32,
  parameter int LSIZE       = 16,
  parameter int MAX_BEATS   = 256,
  parameter int BOUNDARY    = 4096,
  parameter int ID_EXT      = 4,
  parameter int OUTSTANDING = 4
) (
  input  logic                     clock,
  input  logic                     rst_n,
  input  logic                     axi_in_awvalid_i,
  output logic                     axi_in_awready_o,
  input  logic [ASIZE-1:0]         axi_in_awaddr_i,
  input  logic [LSIZE-1:0]         axi_in_awlen_i,
  input  logic [IDSIZE-1:0]        axi_in_awid_i,
  input  logic                     axi_in_wvalid_i,
  output logic                     axi_in_wready_o,
  input  logic [DSIZE-1:0]         axi_in_wdata_i,
  input  logic [DSIZE/8-1:0]       axi_in_wstrb_i,
  input  logic                     axi_in_wlast_i,
  output logic                     axi_in_bvalid_o,
  input  logic                     axi_in_bready_i,
  output logic [IDSIZE-1:0]        axi_in_bid_o,
  output logic [1:0]               axi_in_bresp_o,
  output logic                     axi_out_awvalid_o,
  input  logic                     axi_out_awready_i,
  output logic [ASIZE-1:0]         axi_out_awaddr_o,
  output logic [7:0]               axi_out_awlen_o,
  output logic [IDSIZE+ID_EXT-1:0] axi_out_awid_o,
  output logic [1:0]               axi_out_awburst_o,
  output logic [2:0]               axi_out_awsize_o,
  output logic                     axi_out_wvalid_o,
  input  logic                     axi_out_wready_i,
  output logic [DSIZE-1:0]         axi_out_wdata_o,
  output logic [DSIZE/8-1:0]       axi_out_wstrb_o,
  output logic                     axi_out_wlast_o,
  input  logic                     axi_out_bvalid_i,
  output logic                     axi_out_bready_o,
  input  logic [IDSIZE+ID_EXT-1:0] axi_out_bid_i,
  input  logic [1:0]               axi_out_bresp_i
);

  localparam int BPB  = DSIZE / 8;
  localparam int BSH  = $clog2(BPB);
  localparam int BW   = $clog2(BOUNDARY);
  localparam int OIDW = IDSIZE + ID_EXT;
  localparam int LW   = LSIZE + 1;
  localparam int PW   = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CW   = $clog2(OUTSTANDING + 1);

  typedef enum logic [2:0] {
    IDLE, CALC, ISSUE, WAIT_B, RESP
  } state_e;

  state_e           state_q, state_d;
  logic [ASIZE-1:0] addr_q;
  logic [IDSIZE-1:0] id_q;
  logic [LW-1:0]    rem_q;
  logic [LW-1:0]    sub_q;
  logic [LW-1:0]    bcnt_q;
  logic [LW-1:0]    beat_q;
  logic [1:0]       merged_q;
  logic [8:0]       n_q;
  logic [ASIZE-1:0] awaddr_q;
  logic [7:0]       awlen_q;
  logic [OIDW-1:0]  awid_q;

  logic [8:0]       fifo_mem [OUTSTANDING];
  logic [PW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  logic [8:0]       head;

  logic aw_acc, aw_hs, b_hs, w_hs;
  logic push, pop, full, empty, last_beat;
  logic [31:0] rem32, room32, n32;
  logic [8:0]  n_calc;

  // Burst size: remaining beats, capped by max burst and
  // by the beats left before the next address boundary.
  assign rem32  = 32'(rem_q);
  assign room32 = (32'(BOUNDARY) - 32'(addr_q[BW-1:0])) >> BSH;

  always_comb begin
    n32 = rem32;
    if (n32 > 32'(MAX_BEATS)) n32 = 32'(MAX_BEATS);
    if (n32 > room32) n32 = room32;
  end

  assign n_calc = n32[8:0];

  assign aw_acc = (state_q == IDLE) && axi_in_awvalid_i;
  assign aw_hs  = axi_out_awvalid_o && axi_out_awready_i;
  assign b_hs   = axi_out_bvalid_i && axi_out_bready_o;

  assign full   = (cnt_q == CW'(OUTSTANDING));
  assign empty  = (cnt_q == '0);
  assign head   = fifo_mem[rd_q];

  assign last_beat = !empty &&
                     (beat_q == LW'(head) - LW'(1));
  assign w_hs = axi_in_wvalid_i && axi_out_wready_i && !empty;
  assign pop  = w_hs && last_beat;

  function automatic logic [PW-1:0] ptr_inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(OUTSTANDING - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (axi_in_awvalid_i) state_d = CALC;
      CALC:   if (!full) state_d = ISSUE;
      ISSUE:  if (axi_out_awready_i)
                state_d = (rem_q == LW'(n_q)) ? WAIT_B : CALC;
      WAIT_B: if (bcnt_q == sub_q) state_d = RESP;
      RESP:   if (axi_in_bready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    axi_in_awready_o  = 1'b0;
    axi_out_awvalid_o = 1'b0;
    axi_in_bvalid_o   = 1'b0;
    axi_out_bready_o  = 1'b1;
    push              = 1'b0;
    unique case (state_q)
      IDLE:  axi_in_awready_o = rst_n;
      CALC:  push = !full;
      ISSUE: axi_out_awvalid_o = 1'b1;
      RESP: begin
        axi_in_bvalid_o  = 1'b1;
        axi_out_bready_o = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      id_q     <= '0;
      rem_q    <= '0;
      sub_q    <= '0;
      bcnt_q   <= '0;
      merged_q <= 2'b00;
      n_q      <= '0;
      awaddr_q <= '0;
      awlen_q  <= '0;
      awid_q   <= '0;
    end else begin
      if (aw_acc) begin
        addr_q <= axi_in_awaddr_i;
        id_q   <= axi_in_awid_i;
        rem_q  <= LW'(axi_in_awlen_i) + LW'(1);
        sub_q  <= '0;
      end
      if (state_q == CALC) begin
        awaddr_q <= addr_q;
        awlen_q  <= 8'(n_calc - 9'd1);
        awid_q   <= {id_q, sub_q[ID_EXT-1:0]};
        n_q      <= n_calc;
      end
      if (aw_hs) begin
        addr_q <= addr_q + (ASIZE'(n_q) << BSH);
        rem_q  <= rem_q - LW'(n_q);
        sub_q  <= sub_q + LW'(1);
      end
      if (aw_acc) begin
        bcnt_q   <= '0;
        merged_q <= 2'b00;
      end else if (b_hs) begin
        bcnt_q <= bcnt_q + LW'(1);
        if (axi_out_bresp_i > merged_q)
          merged_q <= axi_out_bresp_i;
      end
    end
  end

  // Sub-burst length FIFO: pushed in CALC, popped on each wlast.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OUTSTANDING; i++)
        fifo_mem[i] <= '0;
    end else if (push) begin
      fifo_mem[wr_q] <= n_calc;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      beat_q <= '0;
    end else begin
      if (push) wr_q <= ptr_inc(wr_q);
      if (pop)  rd_q <= ptr_inc(rd_q);
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: ;
      endcase
      if (w_hs)
        beat_q <= last_beat ? '0 : beat_q + LW'(1);
    end
  end

  assign axi_out_awaddr_o  = awaddr_q;
  assign axi_out_awlen_o   = awlen_q;
  assign axi_out_awid_o    = awid_q;
  assign axi_out_awburst_o = 2'b01;
  assign axi_out_awsize_o  = 3'(BSH);

  assign axi_out_wvalid_o = axi_in_wvalid_i && !empty;
  assign axi_in_wready_o  = axi_out_wready_i && !empty;
  assign axi_out_wdata_o  = axi_in_wdata_i;
  assign axi_out_wstrb_o  = axi_in_wstrb_i;
  assign axi_out_wlast_o  = last_beat;

  assign axi_in_bid_o   = id_q;
  assign axi_in_bresp_o = merged_q;

  // Upstream wlast and downstream bid carry no information here.
  logic unused_ok;
  assign unused_ok = ^{axi_in_wlast_i, axi_out_bid_i, n32[31:9]};

endmodule

// File: tb/tb_axi_long_wr_split.sv
// Directed bench for axi_long_wr_split.
// Ports: none; drives both AXI sides and scores AW, W and B.
module tb_axi_long_wr_split;

  localparam int DSIZE = 64;
  localparam int IDSIZE = 4;
  localparam int ASIZE = 32;
  localparam int LSIZE = 12;
  localparam int ID_EXT = 4;
  localparam int OIDW = IDSIZE + ID_EXT;

  logic clock = 1'b0;
  logic rst_n = 1'b0;

  logic             in_awvalid = 1'b0;
  logic             in_awready;
  logic [ASIZE-1:0] in_awaddr = '0;
  logic [LSIZE-1:0] in_awlen = '0;
  logic [IDSIZE-1:0] in_awid = '0;
  logic             in_wvalid = 1'b0;
  logic             in_wready;
  logic [DSIZE-1:0] in_wdata = '0;
  logic [7:0]       in_wstrb = '0;
  logic             in_wlast = 1'b0;
  logic             in_bvalid;
  logic             in_bready = 1'b0;
  logic [IDSIZE-1:0] in_bid;
  logic [1:0]       in_bresp;
  logic             out_awvalid;
  logic             aw_rdy = 1'b1;
  logic [ASIZE-1:0] out_awaddr;
  logic [7:0]       out_awlen;
  logic [OIDW-1:0]  out_awid;
  logic [1:0]       out_awburst;
  logic [2:0]       out_awsize;
  logic             out_wvalid;
  logic             w_rdy = 1'b1;
  logic [DSIZE-1:0] out_wdata;
  logic [7:0]       out_wstrb;
  logic             out_wlast;
  logic             out_bvalid = 1'b0;
  logic             out_bready;
  logic [OIDW-1:0]  out_bid = '0;
  logic [1:0]       out_bresp = 2'b00;

  always #5 clock = ~clock;

  axi_long_wr_split #(
    .DSIZE(DSIZE), .IDSIZE(IDSIZE), .ASIZE(ASIZE),
    .LSIZE(LSIZE), .MAX_BEATS(256), .BOUNDARY(4096),
    .ID_EXT(ID_EXT), .OUTSTANDING(2)
  ) dut (
    .clock(clock), .rst_n(rst_n),
    .axi_in_awvalid_i(in_awvalid),
    .axi_in_awready_o(in_awready),
    .axi_in_awaddr_i(in_awaddr),
    .axi_in_awlen_i(in_awlen),
    .axi_in_awid_i(in_awid),
    .axi_in_wvalid_i(in_wvalid),
    .axi_in_wready_o(in_wready),
    .axi_in_wdata_i(in_wdata),
    .axi_in_wstrb_i(in_wstrb),
    .axi_in_wlast_i(in_wlast),
    .axi_in_bvalid_o(in_bvalid),
    .axi_in_bready_i(in_bready),
    .axi_in_bid_o(in_bid),
    .axi_in_bresp_o(in_bresp),
    .axi_out_awvalid_o(out_awvalid),
    .axi_out_awready_i(aw_rdy),
    .axi_out_awaddr_o(out_awaddr),
    .axi_out_awlen_o(out_awlen),
    .axi_out_awid_o(out_awid),
    .axi_out_awburst_o(out_awburst),
    .axi_out_awsize_o(out_awsize),
    .axi_out_wvalid_o(out_wvalid),
    .axi_out_wready_i(w_rdy),
    .axi_out_wdata_o(out_wdata),
    .axi_out_wstrb_o(out_wstrb),
    .axi_out_wlast_o(out_wlast),
    .axi_out_bvalid_i(out_bvalid),
    .axi_out_bready_o(out_bready),
    .axi_out_bid_i(out_bid),
    .axi_out_bresp_i(out_bresp)
  );

  // Monitor-owned logs (append only).
  logic [31:0] aw_addr_q [$];
  logic [7:0]  aw_len_q [$];
  logic [7:0]  aw_id_q [$];
  int          wlast_pos [$];
  int aw_cnt = 0, w_cnt = 0, w_out = 0;
  int wlast_cnt = 0, b_cnt = 0;
  int ord_err = 0, attr_err = 0;

  // Main-owned controls.
  int w_end = 0, b0 = 0;
  logic [1:0] bresp_tbl [8];
  int passed = 0, total = 0;
  int aw0, w0, wl0;

  initial forever begin
    @(posedge clock);
    if (out_awvalid && aw_rdy) begin
      aw_addr_q.push_back(out_awaddr);
      aw_len_q.push_back(out_awlen);
      aw_id_q.push_back(out_awid);
      aw_cnt++;
      if (out_awburst !== 2'b01 || out_awsize !== 3'd3)
        attr_err++;
    end
    if (out_wvalid && w_rdy) w_out++;
    if (in_wvalid && in_wready) begin
      if (!out_wvalid || out_wdata !== 64'(w_cnt) ||
          out_wstrb !== 8'(w_cnt))
        ord_err++;
      w_cnt++;
      if (out_wlast) begin
        wlast_pos.push_back(w_cnt);
        wlast_cnt++;
      end
    end
    if (out_bvalid && out_bready) b_cnt++;
  end

  initial forever begin
    @(negedge clock);
    in_wvalid = (w_cnt < w_end);
    in_wdata  = 64'(w_cnt);
    in_wstrb  = 8'(w_cnt);
    in_wlast  = ~in_wlast;
  end

  initial forever begin
    @(negedge clock);
    if (b_cnt < wlast_cnt && b_cnt < aw_cnt) begin
      out_bvalid = 1'b1;
      out_bresp  = bresp_tbl[(b_cnt - b0) & 7];
    end else begin
      out_bvalid = 1'b0;
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
  endtask

  task automatic start_xfer(input logic [31:0] a,
                            input int len,
                            input logic [3:0] id);
    int k;
    aw0 = aw_cnt;
    w0 = w_cnt;
    wl0 = wlast_cnt;
    b0 = b_cnt;
    w_end = w_cnt + len + 1;
    in_awaddr = a;
    in_awlen = 12'(len);
    in_awid = id;
    in_awvalid = 1'b1;
    k = 0;
    while (!in_awready && k < 100) begin
      @(negedge clock);
      k++;
    end
    chk("aw_accept", 64'(in_awready), 64'd1);
    @(negedge clock);
    in_awvalid = 1'b0;
  endtask

  task automatic wait_b(input int budget);
    int k;
    k = 0;
    while (!in_bvalid && k < budget) begin
      @(negedge clock);
      k++;
    end
    chk("b_arrive", 64'(in_bvalid), 64'd1);
  endtask

  task automatic end_b;
    in_bready = 1'b1;
    @(negedge clock);
    in_bready = 1'b0;
    chk("b_single", 64'(in_bvalid), 64'd0);
  endtask

  task automatic chk_aw(input int i, input logic [31:0] a,
                        input logic [7:0] l,
                        input logic [7:0] id);
    chk("aw_addr", 64'(aw_addr_q[aw0+i]), 64'(a));
    chk("aw_len", 64'(aw_len_q[aw0+i]), 64'(l));
    chk("aw_id", 64'(aw_id_q[aw0+i]), 64'(id));
  endtask

  task automatic chk_wl(input int i, input int pos);
    chk("wlast_pos", 64'(wlast_pos[wl0+i] - w0), 64'(pos));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    for (int i = 0; i < 8; i++) bresp_tbl[i] = 2'b00;

    repeat (3) @(negedge clock);
    #1;
    chk("rst_awready", 64'(in_awready), 64'd0);
    chk("rst_awvalid", 64'(out_awvalid), 64'd0);
    chk("rst_wvalid", 64'(out_wvalid), 64'd0);
    chk("rst_wlast", 64'(out_wlast), 64'd0);
    chk("rst_bvalid", 64'(in_bvalid), 64'd0);
    @(negedge clock);
    rst_n = 1'b1;
    #1;
    chk("rel_awready", 64'(in_awready), 64'd1);
    @(negedge clock);

    // 512 beats from 0: two full 256-beat bursts
    start_xfer(32'h0, 511, 4'h5);
    wait_b(3000);
    chk("t1_bresp", 64'(in_bresp), 64'd0);
    chk("t1_bid", 64'(in_bid), 64'h5);
    chk("t1_awcnt", 64'(aw_cnt - aw0), 64'd2);
    chk_aw(0, 32'h0000, 8'd255, 8'h50);
    chk_aw(1, 32'h0800, 8'd255, 8'h51);
    chk("t1_wlcnt", 64'(wlast_cnt - wl0), 64'd2);
    chk_wl(0, 256);
    chk_wl(1, 512);
    chk("t1_beats", 64'(w_cnt - w0), 64'd512);
    end_b();

    // 64 beats at 0xF00: split at 0x1000
    start_xfer(32'h0F00, 63, 4'h2);
    wait_b(1000);
    chk("t2_bresp", 64'(in_bresp), 64'd0);
    chk("t2_awcnt", 64'(aw_cnt - aw0), 64'd2);
    chk_aw(0, 32'h0F00, 8'd31, 8'h20);
    chk_aw(1, 32'h1000, 8'd31, 8'h21);
    chk_wl(0, 32);
    chk_wl(1, 64);
    end_b();

    // single beat
    start_xfer(32'h2008, 0, 4'h7);
    wait_b(500);
    chk("t3_bresp", 64'(in_bresp), 64'd0);
    chk("t3_bid", 64'(in_bid), 64'h7);
    chk("t3_awcnt", 64'(aw_cnt - aw0), 64'd1);
    chk_aw(0, 32'h2008, 8'd0, 8'h70);
    chk_wl(0, 1);
    chk("t3_beats", 64'(w_cnt - w0), 64'd1);
    end_b();

    // 3 bursts, middle SLVERR
    bresp_tbl[0] = 2'b00;
    bresp_tbl[1] = 2'b10;
    bresp_tbl[2] = 2'b00;
    start_xfer(32'h0, 767, 4'h3);
    wait_b(3000);
    chk("t4_bresp", 64'(in_bresp), 64'd2);
    chk("t4_awcnt", 64'(aw_cnt - aw0), 64'd3);
    chk_aw(2, 32'h1000, 8'd255, 8'h32);
    end_b();

    bresp_tbl[1] = 2'b00;
    start_xfer(32'h3000, 15, 4'h3);
    wait_b(500);
    chk("t4_clean", 64'(in_bresp), 64'd0);
    end_b();

    // DECERR dominates SLVERR and EXOKAY
    bresp_tbl[0] = 2'b01;
    bresp_tbl[1] = 2'b11;
    bresp_tbl[2] = 2'b10;
    start_xfer(32'h10000, 767, 4'h9);
    wait_b(3000);
    chk("t4_decerr", 64'(in_bresp), 64'd3);
    end_b();
    for (int i = 0; i < 8; i++) bresp_tbl[i] = 2'b00;

    // W stalled: FIFO depth 2 limits AW run-ahead
    w_rdy = 1'b0;
    start_xfer(32'h5000, 767, 4'h4);
    repeat (50) @(negedge clock);
    chk("t5_aw_held", 64'(aw_cnt - aw0), 64'd2);
    chk("t5_awvalid", 64'(out_awvalid), 64'd0);
    chk("t5_no_w", 64'(w_cnt - w0), 64'd0);
    w_rdy = 1'b1;
    wait_b(3000);
    chk("t5_awcnt", 64'(aw_cnt - aw0), 64'd3);
    chk_aw(0, 32'h5000, 8'd255, 8'h40);
    chk_aw(1, 32'h5800, 8'd255, 8'h41);
    chk_aw(2, 32'h6000, 8'd255, 8'h42);
    chk_wl(0, 256);
    chk_wl(1, 512);
    chk_wl(2, 768);
    chk("t5_bresp", 64'(in_bresp), 64'd0);
    end_b();

    // reset at beat 100 of 512
    start_xfer(32'h0, 511, 4'h6);
    k = 0;
    while ((w_cnt - w0) < 100 && k < 1000) begin
      @(negedge clock);
      k++;
    end
    chk("t6_beat100", 64'(w_cnt - w0), 64'd100);
    rst_n = 1'b0;
    w_end = w_cnt;
    #1;
    chk("t6_awvalid", 64'(out_awvalid), 64'd0);
    chk("t6_wvalid", 64'(out_wvalid), 64'd0);
    chk("t6_wlast", 64'(out_wlast), 64'd0);
    chk("t6_bvalid", 64'(in_bvalid), 64'd0);
    chk("t6_awready", 64'(in_awready), 64'd0);
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    #1;
    chk("t6_rel_rdy", 64'(in_awready), 64'd1);
    @(negedge clock);
    start_xfer(32'h4000, 31, 4'h1);
    wait_b(500);
    chk("t6_bresp", 64'(in_bresp), 64'd0);
    chk("t6_bid", 64'(in_bid), 64'h1);
    chk("t6_awcnt", 64'(aw_cnt - aw0), 64'd1);
    chk_aw(0, 32'h4000, 8'd31, 8'h10);
    chk_wl(0, 32);
    chk("t6_beats", 64'(w_cnt - w0), 64'd32);
    end_b();

    chk("w_order", 64'(ord_err), 64'd0);
    chk("aw_attr", 64'(attr_err), 64'd0);
    chk("w_in_out", 64'(w_out), 64'(w_cnt));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/axi_long_wr_split.md
Name: axi_long_wr_split

Overview:
- Accepts one long AXI write request on a slave write interface. The request carries a wide length field (up to 2^LSIZE beats) and a narrow ID.
- Splits the request into legal AXI4 INCR bursts on a master write interface. Each burst is at most MAX_BEATS beats and never crosses a BOUNDARY-byte address boundary.
- Widens the ID by ID_EXT bits, regenerates wlast per sub-burst, and merges all sub-burst write responses into a single B on the slave side.
- Sits between long-transfer DMA/stream-to-AXI logic and the memory-side AXI4 interconnect.

Parameters:
MAX_BEATS, 256, maximum beats per output burst (power of 2, ≤256)
BOUNDARY, 4096, output bursts never cross a multiple of this byte address (power of 2)
ID_EXT, 4, extra ID bits; out IDSIZE = in IDSIZE + ID_EXT
OUTSTANDING, 4, depth of the pending sub-burst length FIFO (AW allowed ahead of W)

Ports:
clock  input  1  single clock for all logic; axi_in and axi_out share it
rst_n  input  1  asynchronous active-low reset
axi_in  axi_inf.slaver_wr  DSIZE/IDSIZE/ASIZE/LSIZE of the instance  long write request; awlen = beats-1, LSIZE ≤ 24
axi_out  axi_inf.master_wr  same DSIZE/ASIZE, IDSIZE+ID_EXT, LSIZE=8  AXI4 write bursts

Behaviour:
- Clock/reset: one clock (clock), asynchronous active-low reset (rst_n).
- BPB = DSIZE/8 bytes per beat. Addresses are BPB-aligned; no narrow or unaligned bursts.
- FSM states: IDLE, CALC, ISSUE, WAIT_B, RESP.
  - IDLE: axi_in.awready=1. On awvalid, latch addr, id and rem = awlen+1; go to CALC.
  - CALC (1 cycle): n = min(rem, MAX_BEATS, (BOUNDARY - addr%BOUNDARY)/BPB). Load axi_out.awaddr=addr, awlen=n-1, awid={in_id, sub_cnt[ID_EXT-1:0]}, awburst=INCR, awsize=log2(BPB). Push n to the length FIFO.
    - If the FIFO is full, stay in CALC and do not push.
    - Otherwise go to ISSUE.
  - ISSUE: axi_out.awvalid=1 until awready. On the handshake: addr += n*BPB, rem -= n, sub_cnt++. Go to CALC if rem>0, else WAIT_B.
  - WAIT_B: wait until B count == sub_cnt, then go to RESP.
  - RESP: axi_in.bvalid=1, bid=latched id, bresp=merged. Hold until bready, then go to IDLE.
- AW is only accepted in IDLE, so one long transaction is in flight at a time.
- W path (combinational pass-through, zero latency):
  - axi_out.wvalid = axi_in.wvalid & FIFO non-empty.
  - axi_in.wready = axi_out.wready & FIFO non-empty.
  - wdata and wstrb pass straight through.
  - A beat counter against the FIFO head drives axi_out.wlast on the last beat of each sub-burst; the FIFO pops on that beat.
  - axi_in.wlast is ignored. Length is authoritative.
- B path:
  - axi_out.bready=1 in every state except RESP.
  - Each B increments the B count.
  - merged = max(merged, bresp), so DECERR(3) > SLVERR(2) > EXOKAY/OKAY. merged clears on IDLE accept.
- Widths: rem and the beat counters are LSIZE+1 bits. A full 2^LSIZE-beat request must not overflow. The address wraps modulo 2^ASIZE with no error.
- Simultaneous events: FIFO push (CALC) and pop (last W beat) in the same cycle is legal; count is unchanged. A B arriving in the cycle ISSUE exits is counted.
- Reset values: axi_in.awready=0 while rst_n low, 1 the first cycle after release. awvalid, wvalid, wlast, bvalid = 0. All counters 0, FIFO empty, merged=OKAY, FSM=IDLE.
- Reset mid-transfer: all state is dropped immediately with no drain. Downstream recovery is the system's responsibility.

Test Plan:
- DSIZE=64, addr 0x0000, awlen=511 -> two AW: (0x0000, len 255, id {in,0}) and (0x0800, len 255, id {in,1}). wlast on beats 256 and 512; one axi_in B with OKAY after both B.
- DSIZE=64, addr 0x0F00, awlen=63 -> AW (0x0F00, len 31) then (0x1000, len 31). No burst crosses 0x1000.
- awlen=0 at 0x2008 -> single AW with len 0; wlast on beat 1; one B.
- 3-burst transfer, second downstream B = SLVERR, others OKAY -> axi_in.bresp=2. A following clean transfer returns OKAY.
- OUTSTANDING=2, axi_out.wready held 0 for 50 cycles -> exactly 2 AW issued, the third waits in CALC. After release all beats arrive in order with correct wlast positions.
- rst_n pulsed low mid-burst (beat 100 of 512) -> next cycle all valids 0; after release awready=1 and a fresh transfer completes correctly.
